sdfa_cfg_loader: RTL and testbench



---
 rtl/sdfa_cfg_pkg.sv | 33 +++
 rtl/sdfa_serial_rx.sv | 95 +++++++++
 rtl/sdfa_cfg_loader.sv | 190 +++++++++++++++++++
 tb/tb_sdfa_cfg_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfa_cfg_pkg.sv
// sdfa_cfg_pkg: shared FSM encoding, default widths and field helpers for
// the SDFA configuration loader.
// SDFA_CFG_PARITY_EN: when defined, every serial word carries a trailing
// even-parity bit.
package sdfa_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RST = 2'd1,
        RUN      = 2'd2
    } state_e;

    localparam int DEF_MASTER_W   = 29;
    localparam int DEF_BLOCK_W    = 23;
    localparam int DEF_CONV_W     = 3;
    localparam int DEF_LAYER_W    = 3;
    localparam int DEF_NUM_LAYERS = 5;
    localparam int DEF_DEPTH      = 2;

`ifdef SDFA_CFG_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // conv_inf occupies the top CONV_W bits of the master word.
    function automatic int conv_lsb(input int master_w, input int conv_w);
        return master_w - conv_w;
    endfunction

    localparam int DEF_CONV_LSB = conv_lsb(DEF_MASTER_W, DEF_CONV_W);

endpackage

// File: rtl/sdfa_serial_rx.sv
// sdfa_serial_rx: MSB-first 1-bit deserialiser that holds a completed word
// until the consumer clears it.
// SDFA_CFG_PARITY_EN: frames are W data bits plus one even-parity bit; a
// parity mismatch discards the word.
module sdfa_serial_rx
    import sdfa_cfg_pkg::*;
#(
    parameter int W = DEF_BLOCK_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid,
    input  logic         bit_in,
    input  logic         clr,
    output logic [W-1:0] word,
    output logic         word_avail,
    output logic         ovw_err,
    output logic         par_err
);

    localparam int FRAME_W = W + PARITY_BITS;
    localparam int SHIFT_W = W - 1 + PARITY_BITS;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       word_q, word_d;
    logic               ready_q, ready_d;
    logic [W-1:0]       rx_word;
    logic               done_now;

    // Shift and count the incoming frame; flag the cycle a word completes.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        done_now = 1'b0;
        par_err  = 1'b0;
`ifdef SDFA_CFG_PARITY_EN
        // The parity bit is never shifted; the data bits are already complete.
        rx_word = shift_q;
        if (valid) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (^{shift_q, bit_in}) par_err  = 1'b1;
                else                    done_now = 1'b1;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                shift_d = {shift_q[SHIFT_W-2:0], bit_in};
            end
        end
`else
        // The last bit goes straight into the word, so only W-1 bits are stored.
        rx_word = {shift_q, bit_in};
        if (valid) begin
            shift_d = rx_word[SHIFT_W-1:0];
            if (cnt_q == LAST_CNT) begin
                cnt_d    = '0;
                done_now = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // A completed word is offered the same cycle and held until cleared.
    assign word_avail = ready_q | done_now;
    assign word       = done_now ? rx_word : word_q;
    assign ovw_err    = done_now & ready_q;

    // Next-state for the held word and its ready flag.
    always_comb begin
        word_d  = word;
        ready_d = clr ? 1'b0 : word_avail;
    end

    // Register receive state; reset discards any partial word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/sdfa_cfg_loader.sv
// sdfa_cfg_loader: deserialises master/block configuration streams, pairs
// them into layer entries buffered in a DEPTH-deep FIFO, and sequences
// layers against the datapath handshakes.
// SDFA_CFG_PARITY_EN: enables per-word even parity in both receivers.
module sdfa_cfg_loader
    import sdfa_cfg_pkg::*;
#(
    parameter int MASTER_W   = DEF_MASTER_W,
    parameter int BLOCK_W    = DEF_BLOCK_W,
    parameter int CONV_W     = DEF_CONV_W,
    parameter int LAYER_W    = DEF_LAYER_W,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                set_up_req,
    input  logic                master_inf_valid,
    input  logic                block_inf_valid,
    input  logic                master_in,
    input  logic                block_in,
    input  logic                reset_done,
    input  logic                in_filled,
    input  logic                master_done,
    output logic                ready,
    output logic [BLOCK_W-1:0]  block_inf_out,
    output logic [MASTER_W-1:0] master_inf_out,
    output logic [CONV_W-1:0]   conv_inf,
    output logic [LAYER_W-1:0]  layer,
    output logic                layer_start,
    output logic                cfg_err
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int PTR_CW   = PTR_W + 1;
    localparam int CONV_LSB = conv_lsb(MASTER_W, CONV_W);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    typedef struct packed {
        logic [MASTER_W-1:0] master;
        logic [BLOCK_W-1:0]  block;
    } entry_t;

    // Receivers
    logic [MASTER_W-1:0] m_word;
    logic [BLOCK_W-1:0]  b_word;
    logic m_avail, b_avail, m_ovw, b_ovw, m_par, b_par;
    logic push_req;

    sdfa_serial_rx #(.W(MASTER_W)) u_master_rx (
        .clk        (clk),
        .rstn       (rstn),
        .valid      (master_inf_valid),
        .bit_in     (master_in),
        .clr        (push_req),
        .word       (m_word),
        .word_avail (m_avail),
        .ovw_err    (m_ovw),
        .par_err    (m_par)
    );

    sdfa_serial_rx #(.W(BLOCK_W)) u_block_rx (
        .clk        (clk),
        .rstn       (rstn),
        .valid      (block_inf_valid),
        .bit_in     (block_in),
        .clr        (push_req),
        .word       (b_word),
        .word_avail (b_avail),
        .ovw_err    (b_ovw),
        .par_err    (b_par)
    );

    // An entry forms as soon as both halves are available.
    assign push_req = m_avail & b_avail;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    entry_t              fifo_mem [DEPTH];
    logic [PTR_CW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                fifo_empty, fifo_full;
    logic                push_ok, push_drop, pop;
    logic                cfg_err_q, cfg_err_d;
    entry_t              head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign set_up_req = !fifo_full;

    // Accept or drop the assembled entry, advance pointers, accumulate errors.
    always_comb begin
        push_ok   = push_req && (!fifo_full || pop);
        push_drop = push_req && !push_ok;
        wr_ptr_d  = wr_ptr_q + PTR_CW'(push_ok);
        rd_ptr_d  = rd_ptr_q + PTR_CW'(pop);
        cfg_err_d = cfg_err_q | push_drop | m_ovw | b_ovw | m_par | b_par;
    end

    // Write the FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; pointers alone define valid contents.
        if (push_ok) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= entry_t'{master: m_word, block: b_word};
    end

    // Register FIFO pointers and the sticky error flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Layer sequencer state and registered outputs
    state_e              state_q, state_d;
    logic [MASTER_W-1:0] master_act_q, master_act_d;
    logic [BLOCK_W-1:0]  block_act_q, block_act_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic                ready_q, ready_d;
    logic                layer_start_q, layer_start_d;

    // Sequencer next state: pop in IDLE, await datapath in WAIT_RST, run until done.
    always_comb begin
        state_d       = state_q;
        master_act_d  = master_act_q;
        block_act_d   = block_act_q;
        layer_d       = layer_q;
        ready_d       = ready_q;
        layer_start_d = 1'b0;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    master_act_d = head.master;
                    block_act_d  = head.block;
                    state_d      = WAIT_RST;
                end
            end
            WAIT_RST: begin
                if (reset_done && in_filled) begin
                    state_d       = RUN;
                    ready_d       = 1'b1;
                    layer_start_d = 1'b1;
                end
            end
            RUN: begin
                if (master_done) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register sequencer state and its outputs together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            master_act_q  <= '0;
            block_act_q   <= '0;
            layer_q       <= '0;
            ready_q       <= 1'b0;
            layer_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            master_act_q  <= master_act_d;
            block_act_q   <= block_act_d;
            layer_q       <= layer_d;
            ready_q       <= ready_d;
            layer_start_q <= layer_start_d;
        end
    end

    assign ready          = ready_q;
    assign master_inf_out = master_act_q;
    assign block_inf_out  = block_act_q;
    assign conv_inf       = master_act_q[CONV_LSB +: CONV_W];
    assign layer          = layer_q;
    assign layer_start    = layer_start_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_sdfa_cfg_loader.sv
// tb_sdfa_cfg_loader: scoreboard bench for sdfa_cfg_loader. Stimulus pushes
// expected layer entries; an independent monitor checks each layer start.
// SDFA_CFG_PARITY_EN: frames gain an even-parity bit and a bad-parity case runs.
`timescale 1ns/1ps
module tb_sdfa_cfg_loader;
    import sdfa_cfg_pkg::*;

    localparam int MW = DEF_MASTER_W;
    localparam int BW = DEF_BLOCK_W;
    localparam int CW = DEF_CONV_W;
    localparam int LW = DEF_LAYER_W;
    localparam int NL = DEF_NUM_LAYERS;
    localparam int DP = DEF_DEPTH;
`ifdef SDFA_CFG_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic master_inf_valid = 1'b0, block_inf_valid = 1'b0;
    logic master_in = 1'b0, block_in = 1'b0;
    logic reset_done, in_filled, master_done;
    logic set_up_req, ready, layer_start, cfg_err;
    logic [BW-1:0] block_inf_out;
    logic [MW-1:0] master_inf_out;
    logic [CW-1:0] conv_inf;
    logic [LW-1:0] layer;

    always #5 clk = ~clk;

    sdfa_cfg_loader #(
        .MASTER_W(MW), .BLOCK_W(BW), .CONV_W(CW),
        .LAYER_W(LW), .NUM_LAYERS(NL), .DEPTH(DP)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .set_up_req       (set_up_req),
        .master_inf_valid (master_inf_valid),
        .block_inf_valid  (block_inf_valid),
        .master_in        (master_in),
        .block_in         (block_in),
        .reset_done       (reset_done),
        .in_filled        (in_filled),
        .master_done      (master_done),
        .ready            (ready),
        .block_inf_out    (block_inf_out),
        .master_inf_out   (master_inf_out),
        .conv_inf         (conv_inf),
        .layer            (layer),
        .layer_start      (layer_start),
        .cfg_err          (cfg_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Datapath handshakes: manual values for directed steps, random otherwise.
    bit   dp_mode = 1'b0;
    logic man_rd = 1'b0, man_if = 1'b0, man_md = 1'b0;
    logic rnd_rd = 1'b0, rnd_if = 1'b0, rnd_md = 1'b0;

    always @(negedge clk) begin
        rnd_rd = ($urandom_range(0, 1) == 1);
        rnd_if = ($urandom_range(0, 1) == 1);
        rnd_md = ($urandom_range(0, 3) == 0);
    end

    assign reset_done  = dp_mode ? rnd_rd : man_rd;
    assign in_filled   = dp_mode ? rnd_if : man_if;
    assign master_done = dp_mode ? rnd_md : man_md;

    // Reference model: entries start in the order they were accepted, and the
    // layer index counts starts modulo NL.
    typedef struct {
        logic [MW-1:0] m;
        logic [BW-1:0] b;
    } pair_t;

    pair_t exp_q[$];
    int    exp_layer = 0;

    always @(negedge clk) begin : monitor
        pair_t e;
        if (!rstn) begin
            exp_q.delete();
            exp_layer = 0;
        end else if (layer_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_layer_start: got a start at layer %0d, expected none", layer);
            end else begin
                e = exp_q.pop_front();
                check("start_master", 64'(master_inf_out), 64'(e.m));
                check("start_block", 64'(block_inf_out), 64'(e.b));
                check("start_conv", 64'(conv_inf), 64'(e.m[MW-1 -: CW]));
                check("start_layer", 64'(layer), 64'(exp_layer));
                check("start_ready", 64'(ready), 64'd1);
                exp_layer = (exp_layer + 1) % NL;
            end
        end
    end

    function automatic logic [63:0] mk_frame(input logic [63:0] w);
`ifdef SDFA_CFG_PARITY_EN
        return {w[62:0], ^w};
`else
        return w;
`endif
    endfunction

    task automatic drive(input bit is_master, input logic v, input logic b);
        if (is_master) begin
            master_inf_valid = v;
            master_in        = b;
        end else begin
            block_inf_valid = v;
            block_in        = b;
        end
    endtask

    task automatic send_bits(input bit is_master, input logic [63:0] frame, input int n,
                             input int lead, input bit gaps);
        int i;
        for (int k = 0; k < lead; k++) @(negedge clk);
        i = n - 1;
        while (i >= 0) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(is_master, 1'b0, 1'b0);
            end else begin
                drive(is_master, 1'b1, frame[i]);
                i--;
            end
        end
        @(negedge clk);
        drive(is_master, 1'b0, 1'b0);
    endtask

    task automatic send_pair(input logic [MW-1:0] m, input logic [BW-1:0] b,
                             input int m_lead, input int b_lead, input bit gaps,
                             input bit m_flip);
        logic [63:0] mf, bf;
        mf = mk_frame(64'(m)) ^ 64'(m_flip);
        bf = mk_frame(64'(b));
        fork
            send_bits(1'b1, mf, MW + PB, m_lead, gaps);
            send_bits(1'b0, bf, BW + PB, b_lead, gaps);
        join
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_space(input int budget);
        int n = 0;
        while (!set_up_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("space_wait", 64'(set_up_req), 64'd1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        pair_t p;
        int    occ;
        int    lead;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_set_up_req", 64'(set_up_req), 64'd1);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_layer", 64'(layer), 64'd0);
        check("rst_layer_start", 64'(layer_start), 64'd0);
        check("rst_master", 64'(master_inf_out), 64'd0);
        check("rst_block", 64'(block_inf_out), 64'd0);
        check("rst_conv", 64'(conv_inf), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single entry, manual handshakes
        p.m = MW'(32'h1ABCDEF1);
        p.b = BW'(32'h5A5A5A);
        exp_q.push_back(p);
        send_pair(p.m, p.b, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_master", 64'(master_inf_out), 64'(p.m));
        check("single_conv", 64'(conv_inf), 64'(p.m[MW-1 -: CW]));
        check("single_block", 64'(block_inf_out), 64'(p.b));
        check("single_wait_ready", 64'(ready), 64'd0);
        man_rd = 1'b1;
        man_if = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
        man_if = 1'b0;
        check("single_start_pulse", 64'(layer_start), 64'd1);
        check("single_layer", 64'(layer), 64'd0);
        @(negedge clk);
        check("single_start_end", 64'(layer_start), 64'd0);
        check("single_run_ready", 64'(ready), 64'd1);

        // Overflow: FSM holds in RUN, so nothing pops while three entries arrive
        occ = 0;
        for (int k = 0; k < 3; k++) begin
            p.m = MW'($urandom);
            p.b = BW'($urandom);
            check("ovf_set_up_req", 64'(set_up_req), 64'(occ < DP));
            check("ovf_err_before", 64'(cfg_err), 64'd0);
            if (occ < DP) begin
                exp_q.push_back(p);
                occ++;
            end
            send_pair(p.m, p.b, 0, 0, 1'b0, 1'b0);
        end
        check("ovf_cfg_err", 64'(cfg_err), 64'd1);
        check("ovf_full", 64'(set_up_req), 64'd0);

        // master_done ends the layer and advances the index
        man_md = 1'b1;
        @(negedge clk);
        man_md = 1'b0;
        check("done_ready", 64'(ready), 64'd0);
        check("done_layer", 64'(layer), 64'(1 % NL));
        dp_mode = 1'b1;
        wait_drain(2000);
        check("ovf_err_sticky", 64'(cfg_err), 64'd1);

        // Reset in the middle of a master word
        dp_mode = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'($urandom));
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready), 64'd0);
        check("mid_rst_layer", 64'(layer), 64'd0);
        check("mid_rst_master", 64'(master_inf_out), 64'd0);
        check("mid_rst_block", 64'(block_inf_out), 64'd0);
        check("mid_rst_cfg_err", 64'(cfg_err), 64'd0);
        check("mid_rst_set_up_req", 64'(set_up_req), 64'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        dp_mode = 1'b1;
        p.m = MW'($urandom);
        p.b = BW'($urandom);
        exp_q.push_back(p);
        send_pair(p.m, p.b, 0, 0, 1'b1, 1'b0);
        wait_drain(2000);

        // Skew: block word completes 40 cycles before the master word
        p.m = MW'($urandom);
        p.b = BW'($urandom);
        exp_q.push_back(p);
        send_pair(p.m, p.b, BW + 40 - MW, 0, 1'b0, 1'b0);
        check("skew_cfg_err", 64'(cfg_err), 64'd0);
        wait_drain(2000);
        repeat (60) @(negedge clk);
        check("skew_err_after", 64'(cfg_err), 64'd0);

        // Random entries with gaps and skew; layers wrap through NL
        for (int k = 0; k < 10; k++) begin
            wait_space(5000);
            p.m  = MW'($urandom);
            p.b  = BW'($urandom);
            lead = $urandom_range(0, 15);
            exp_q.push_back(p);
            if ($urandom_range(0, 1) == 1) send_pair(p.m, p.b, lead, 0, 1'b1, 1'b0);
            else                          send_pair(p.m, p.b, 0, lead, 1'b1, 1'b0);
        end
        wait_drain(4000);
        check("rand_cfg_err", 64'(cfg_err), 64'd0);

`ifdef SDFA_CFG_PARITY_EN
        // Flipped parity on the master word: no entry, error flagged
        p.m = MW'($urandom);
        p.b = BW'($urandom);
        send_pair(p.m, p.b, 0, 0, 1'b0, 1'b1);
        check("parity_cfg_err", 64'(cfg_err), 64'd1);
        repeat (60) @(negedge clk);
        check("parity_no_entry", 64'(set_up_req), 64'd1);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
